// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the MEM-stage load/store controller.
//   state_e      : controller states
//   F3_*         : RISC-V fun3 encodings handled by the byte-lane wrapper
//   access_legal : (store, fun3, byte offset) -> access is supported
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Halfwords may sit at offsets 00/01/10 because the wrapper shifts within
  // the word; only an access crossing the word boundary is rejected.
  // Unsigned variants only make sense for loads.
  function automatic logic access_legal(input logic       store,
                                        input logic [2:0] fun3,
                                        input logic [1:0] off);
    logic legal;
    legal = 1'b0;
    case (fun3)
      F3_B:    legal = 1'b1;
      F3_H:    legal = (off != 2'b11);
      F3_W:    legal = (off == 2'b00);
      F3_BU:   legal = !store;
      F3_HU:   legal = !store && (off != 2'b11);
      F3_WU:   legal = !store && (off == 2'b00);
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align_chk.sv
// lsu_align_chk: combinational legality check of a load/store access.
// Also instantiated by the trap unit to classify the same fault.
//   store : 1 = store, 0 = load
//   fun3  : RISC-V fun3 of the access
//   off   : byte address bits [1:0]
//   legal : 1 when the access is supported
module lsu_align_chk
  import lsu_pkg::*;
(
  input  logic       store,
  input  logic [2:0] fun3,
  input  logic [1:0] off,
  output logic       legal
);

  assign legal = access_legal(store, fun3, off);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store sequencer between the pipeline and the
// data memory / byte-lane wrapper. One access at a time; stalls the pipeline
// until the memory acknowledges, or raises a one-cycle error pulse.
//
//   state | meaning
//   IDLE  | waiting; stall follows req_valid, request latched on accept
//   REQ   | dmem_req held until dmem_ack or TIMEOUT cycles elapse
//   RESP  | done_o pulse, wrap_load for loads, pipeline released
//   ERR   | err_align or err_timeout pulse, pipeline released
//
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   req_valid/store/fun3/addr/wdata : pipeline request
//   stall_o, done_o, rdata_o    : pipeline handshake and captured read word
//   err_align, err_timeout      : trap pulses
//   wrap_*                      : byte-lane wrapper controls (latched)
//   dmem_req/we/addr, dmem_ack/rdata : data-memory handshake
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [2:0]        req_fun3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              err_align,
  output logic              err_timeout,
  output logic              wrap_mem_en,
  output logic              wrap_load,
  output logic [1:0]        wrap_byteadd,
  output logic [2:0]        wrap_fun3,
  output logic [31:0]       wrap_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Expiry is detected on the last allowed REQ cycle so that dmem_req is
  // asserted for exactly TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              store_q;
  logic [2:0]        fun3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              tmo_q;
  logic              legal;
  logic              expire;

  lsu_align_chk u_align_chk (
    .store (req_store),
    .fun3  (req_fun3),
    .off   (req_addr[1:0]),
    .legal (legal)
  );

  assign expire = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      fun3_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            store_q <= req_store;
            fun3_q  <= req_fun3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            if (!store_q) rdata_q <= dmem_rdata;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (expire) tmo_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    stall_o     = 1'b0;
    done_o      = 1'b0;
    err_align   = 1'b0;
    err_timeout = 1'b0;
    wrap_mem_en = 1'b0;
    wrap_load   = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated with rst_n so the stall drops the instant reset asserts,
        // even while the pipeline still holds req_valid.
        stall_o = req_valid && rst_n;
        if (req_valid) state_d = legal ? REQ : ERR;
      end
      REQ: begin
        stall_o     = 1'b1;
        dmem_req    = 1'b1;
        dmem_we     = store_q;
        wrap_mem_en = store_q;
        if (dmem_ack)    state_d = RESP;
        else if (expire) state_d = ERR;
      end
      RESP: begin
        done_o    = 1'b1;
        wrap_load = !store_q;
        state_d   = IDLE;
      end
      ERR: begin
        err_align   = !tmo_q;
        err_timeout = tmo_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata_o      = rdata_q;
  assign wrap_byteadd = addr_q[1:0];
  assign wrap_fun3    = fun3_q;
  assign wrap_data    = wdata_q;
  assign dmem_addr    = {addr_q[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: self-checking bench for lsu_mem_ctrl. Two instances share
// the request bus: dut (TIMEOUT=15) and dut_b (TIMEOUT=4); sel_b routes
// req_valid/dmem_ack and the observed outputs to one of them.
module tb_lsu_mem_ctrl;

  localparam int T_A = 15;
  localparam int T_B = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_v, sel_b, ack;
  logic        req_store;
  logic [2:0]  req_fun3;
  logic [31:0] req_addr, req_wdata, dmem_rdata;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic a_stall, a_done, a_erra, a_errt, a_memen, a_load, a_req, a_we;
  logic b_stall, b_done, b_erra, b_errt, b_memen, b_load, b_req, b_we;
  logic [31:0] a_rdata, a_wdata, a_addr, b_rdata, b_wdata, b_addr;
  logic [1:0]  a_ba, b_ba;
  logic [2:0]  a_f3, b_f3;

  lsu_mem_ctrl #(.TIMEOUT(T_A), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_v && !sel_b), .req_store(req_store),
    .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall_o(a_stall), .done_o(a_done), .rdata_o(a_rdata), .err_align(a_erra),
    .err_timeout(a_errt), .wrap_mem_en(a_memen), .wrap_load(a_load),
    .wrap_byteadd(a_ba), .wrap_fun3(a_f3), .wrap_data(a_wdata),
    .dmem_req(a_req), .dmem_we(a_we), .dmem_addr(a_addr),
    .dmem_ack(ack && !sel_b), .dmem_rdata(dmem_rdata)
  );

  lsu_mem_ctrl #(.TIMEOUT(T_B), .ADDR_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_v && sel_b), .req_store(req_store),
    .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall_o(b_stall), .done_o(b_done), .rdata_o(b_rdata), .err_align(b_erra),
    .err_timeout(b_errt), .wrap_mem_en(b_memen), .wrap_load(b_load),
    .wrap_byteadd(b_ba), .wrap_fun3(b_f3), .wrap_data(b_wdata),
    .dmem_req(b_req), .dmem_we(b_we), .dmem_addr(b_addr),
    .dmem_ack(ack && sel_b), .dmem_rdata(dmem_rdata)
  );

  logic o_stall, o_done, o_erra, o_errt, o_memen, o_load, o_req, o_we;
  logic [31:0] o_rdata, o_wdata, o_addr;
  logic [1:0]  o_ba;
  logic [2:0]  o_f3;
  assign o_stall = sel_b ? b_stall : a_stall;
  assign o_done  = sel_b ? b_done  : a_done;
  assign o_erra  = sel_b ? b_erra  : a_erra;
  assign o_errt  = sel_b ? b_errt  : a_errt;
  assign o_memen = sel_b ? b_memen : a_memen;
  assign o_load  = sel_b ? b_load  : a_load;
  assign o_req   = sel_b ? b_req   : a_req;
  assign o_we    = sel_b ? b_we    : a_we;
  assign o_rdata = sel_b ? b_rdata : a_rdata;
  assign o_wdata = sel_b ? b_wdata : a_wdata;
  assign o_addr  = sel_b ? b_addr  : a_addr;
  assign o_ba    = sel_b ? b_ba    : a_ba;
  assign o_f3    = sel_b ? b_f3    : a_f3;

  int n_checks = 0;
  int n_fail   = 0;

  // per-transaction observations
  int          r_req, r_stall, r_done_cyc;
  logic        r_done, r_erra, r_errt, r_stall_end, r_wload;
  logic        r_we_any, r_memen_any, r_load_any, r_hold_bad, r_quiet, r_bound;
  logic [31:0] r_rdata;
  logic [31:0] exp_rd;

  // Reference legality: an access of 2**size bytes must fit inside its word;
  // size 3 does not exist and unsigned forms are load-only.
  function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [1:0] off);
    int bytes;
    if (f3[1:0] == 2'b11) return 1'b0;
    if (f3[2] && st) return 1'b0;
    bytes = 1 << f3[1:0];
    return (int'(off) + bytes) <= 4;
  endfunction

  // Drives one request, acks on REQ cycle ack_at (never if 0), records what
  // the selected DUT does. With b2b the request stays valid for the caller.
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int ack_at, input logic [31:0] rd,
                         input bit b2b);
    bit fin;
    int n;
    r_req = 0; r_stall = 0; r_done_cyc = -1;
    r_done = 0; r_erra = 0; r_errt = 0; r_stall_end = 1'b1; r_wload = 0;
    r_we_any = 0; r_memen_any = 0; r_load_any = 0; r_hold_bad = 0; r_quiet = 1; r_bound = 0;
    r_rdata = '0;
    req_store = st; req_fun3 = f3; req_addr = a; req_wdata = wd; req_v = 1'b1;
    fin = 0; n = 0;
    while (!fin && n < 64) begin
      @(negedge clk);
      n++;
      if (o_req) begin
        r_req++;
        if (o_addr !== {a[31:2], 2'b00} || o_ba !== a[1:0] || o_f3 !== f3 || o_wdata !== wd)
          r_hold_bad = 1;
        if (r_req == ack_at) begin ack = 1'b1; dmem_rdata = rd; end
      end
      if (o_stall) r_stall++;
      if (o_we) r_we_any = 1;
      if (o_memen) r_memen_any = 1;
      if (o_load) r_load_any = 1;
      if (o_done || o_erra || o_errt) begin
        fin = 1;
        r_done = o_done; r_erra = o_erra; r_errt = o_errt;
        r_stall_end = o_stall; r_rdata = o_rdata; r_wload = o_load; r_done_cyc = cyc;
        if (o_done && (o_addr !== {a[31:2], 2'b00} || o_ba !== a[1:0] || o_f3 !== f3))
          r_hold_bad = 1;
      end
      @(posedge clk);
      #1;
      ack = 1'b0;
    end
    if (!fin) r_bound = 1;
    if (!b2b) begin
      req_v = 1'b0;
      @(negedge clk);
      r_quiet = !(o_done || o_erra || o_errt || o_req || o_stall);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({a_stall, a_done, a_erra, a_errt, a_memen, a_load, a_req, a_we, a_rdata, a_wdata, a_addr, a_ba, a_f3} !== '0) begin
      n_fail++; $display("FAIL reset_a: outputs not all zero (rdata=%h addr=%h req=%b)", a_rdata, a_addr, a_req);
    end
    n_checks++;
    if ({b_stall, b_done, b_erra, b_errt, b_memen, b_load, b_req, b_we, b_rdata, b_wdata, b_addr, b_ba, b_f3} !== '0) begin
      n_fail++; $display("FAIL reset_b: outputs not all zero (rdata=%h addr=%h req=%b)", b_rdata, b_addr, b_req);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_rd = '0;
  endtask

  task automatic test_load();
    run_txn(1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b0);
    exp_rd = 32'hDEADBEEF;
    n_checks++;
    if (r_req !== 3 || r_stall !== 4) begin
      n_fail++; $display("FAIL load_timing: req=%0d stall=%0d, want 3/4", r_req, r_stall);
    end
    n_checks++;
    if ({r_done, r_wload, r_stall_end, r_hold_bad, r_bound} !== 5'b11000) begin
      n_fail++; $display("FAIL load_resp: done/wload/stall/holdbad/bound=%b want 11000", {r_done, r_wload, r_stall_end, r_hold_bad, r_bound});
    end
    n_checks++;
    if (r_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_rdata: got %h want deadbeef", r_rdata);
    end
  endtask

  task automatic test_store();
    run_txn(1'b1, 3'b000, 32'h103, 32'hAB, 1, 32'h5555_AAAA, 1'b0);
    n_checks++;
    if (r_req !== 1 || {r_we_any, r_memen_any, r_hold_bad} !== 3'b110) begin
      n_fail++; $display("FAIL store_req: req=%0d we/memen/holdbad=%b want 1/110", r_req, {r_we_any, r_memen_any, r_hold_bad});
    end
    n_checks++;
    if ({r_done, r_load_any, r_quiet} !== 3'b101) begin
      n_fail++; $display("FAIL store_resp: done/load/quiet=%b want 101", {r_done, r_load_any, r_quiet});
    end
    n_checks++;
    if (r_rdata !== exp_rd) begin
      n_fail++; $display("FAIL store_rdata_hold: got %h want %h", r_rdata, exp_rd);
    end
  endtask

  task automatic test_align_err();
    run_txn(1'b0, 3'b001, 32'h203, 32'h0, 1, 32'h0, 1'b0);
    n_checks++;
    if (r_req !== 0 || r_stall !== 1 || {r_erra, r_errt, r_done, r_stall_end, r_quiet} !== 5'b10001) begin
      n_fail++; $display("FAIL align_lh: req=%0d stall=%0d flags=%b want 0/1/10001", r_req, r_stall, {r_erra, r_errt, r_done, r_stall_end, r_quiet});
    end
    run_txn(1'b1, 3'b100, 32'h200, 32'h1, 1, 32'h0, 1'b0);
    n_checks++;
    if (r_req !== 0 || {r_erra, r_errt, r_done, r_we_any, r_quiet} !== 5'b10001) begin
      n_fail++; $display("FAIL align_sw_f3: req=%0d flags=%b want 0/10001", r_req, {r_erra, r_errt, r_done, r_we_any, r_quiet});
    end
  endtask

  task automatic test_timeout();
    sel_b = 1'b1;
    run_txn(1'b0, 3'b010, 32'h300, 32'h0, 0, 32'h0, 1'b0);
    n_checks++;
    if (r_req !== T_B || {r_errt, r_erra, r_done, r_stall_end, r_quiet} !== 5'b10001) begin
      n_fail++; $display("FAIL timeout: req=%0d flags=%b want %0d/10001", r_req, {r_errt, r_erra, r_done, r_stall_end, r_quiet}, T_B);
    end
    run_txn(1'b0, 3'b010, 32'h304, 32'h0, T_B, 32'h0BAD_F00D, 1'b0);
    n_checks++;
    if (r_req !== T_B || {r_done, r_errt} !== 2'b10 || r_rdata !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL ack_at_expiry: req=%0d done/errt=%b rdata=%h want %0d/10/0badf00d", r_req, {r_done, r_errt}, r_rdata, T_B);
    end
    sel_b = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit saw_pulse;
    req_store = 1'b0; req_fun3 = 3'b010; req_addr = 32'h40; req_wdata = '0; req_v = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (a_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: dmem_req=%b want 1 in 2nd REQ cycle", a_req);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_req, a_stall} !== 2'b00) begin
      n_fail++; $display("FAIL rst_async: req/stall=%b want 00", {a_req, a_stall});
    end
    saw_pulse = 0;
    repeat (2) begin
      @(negedge clk);
      if (a_done || a_erra || a_errt || a_stall) saw_pulse = 1;
    end
    n_checks++;
    if (saw_pulse !== 1'b0) begin
      n_fail++; $display("FAIL rst_pulses: pulse/stall seen during reset=%b want 0", saw_pulse);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_rd = '0;
    run_txn(1'b0, 3'b010, 32'h40, 32'h0, 2, 32'h1234_5678, 1'b0);
    exp_rd = 32'h1234_5678;
    n_checks++;
    if (r_req !== 2 || r_done !== 1'b1 || r_rdata !== 32'h1234_5678 || r_hold_bad !== 1'b0) begin
      n_fail++; $display("FAIL rst_retry: req=%0d done=%b rdata=%h want 2/1/12345678", r_req, r_done, r_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int c1;
    logic [31:0] rd;
    rd = $urandom;
    run_txn(1'b1, 3'b010, 32'h10, 32'hCAFE_0001, 1, 32'h0, 1'b1);
    c1 = r_done_cyc;
    n_checks++;
    if (r_done !== 1'b1 || r_we_any !== 1'b1) begin
      n_fail++; $display("FAIL b2b_sw: done/we=%b want 11", {r_done, r_we_any});
    end
    run_txn(1'b0, 3'b010, 32'h14, 32'h0, 1, rd, 1'b0);
    exp_rd = rd;
    n_checks++;
    if (r_done_cyc - c1 !== 3 || r_we_any !== 1'b0 || r_rdata !== rd) begin
      n_fail++; $display("FAIL b2b_lw: gap=%0d we=%b rdata=%h want 3/0/%h", r_done_cyc - c1, r_we_any, r_rdata, rd);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a, wd, rd;
      int          ack_at, e_req, e_stall;
      bit          lg, ok_done;
      logic [2:0]  e_flags;
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = $urandom; wd = $urandom; rd = $urandom;
      ack_at = $urandom_range(1, T_A + 3);
      lg = m_legal(st, f3, a[1:0]);
      ok_done = lg && (ack_at <= T_A);
      run_txn(st, f3, a, wd, ack_at, rd, 1'b0);
      if (!lg) begin
        e_req = 0; e_stall = 1; e_flags = 3'b010;
      end else if (ok_done) begin
        e_req = ack_at; e_stall = ack_at + 1; e_flags = 3'b100;
        if (!st) exp_rd = rd;
      end else begin
        e_req = T_A; e_stall = T_A + 1; e_flags = 3'b001;
      end
      n_checks++;
      if (r_req !== e_req || r_stall !== e_stall || {r_done, r_erra, r_errt} !== e_flags || r_bound !== 1'b0) begin
        n_fail++; $display("FAIL rand_seq[%0d]: st=%b f3=%b a=%h ack=%0d req=%0d stall=%0d flags=%b want %0d/%0d/%b",
                           i, st, f3, a, ack_at, r_req, r_stall, {r_done, r_erra, r_errt}, e_req, e_stall, e_flags);
      end
      n_checks++;
      if ({r_we_any, r_memen_any, r_load_any} !== {lg && st, lg && st, ok_done && !st} ||
          r_hold_bad !== 1'b0 || r_quiet !== 1'b1 || r_stall_end !== 1'b0) begin
        n_fail++; $display("FAIL rand_ctl[%0d]: we/memen/load=%b holdbad=%b quiet=%b stall_end=%b",
                           i, {r_we_any, r_memen_any, r_load_any}, r_hold_bad, r_quiet, r_stall_end);
      end
      n_checks++;
      if (r_rdata !== exp_rd) begin
        n_fail++; $display("FAIL rand_rdata[%0d]: got %h want %h", i, r_rdata, exp_rd);
      end
    end
  endtask

  initial begin
    req_v = 1'b0; sel_b = 1'b0; ack = 1'b0;
    req_store = 1'b0; req_fun3 = '0; req_addr = '0; req_wdata = '0; dmem_rdata = '0;
    exp_rd = '0;
    test_reset();
    test_load();
    test_store();
    test_align_err();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store sequencing controller in the MEM stage, placed between the pipeline and the byte-lane memory wrapper plus the data memory. It accepts one load or store request at a time and checks alignment and the fun3 encoding. It drives the data-memory request/acknowledge handshake, stalls the pipeline until completion, and presents the wrapper controls: mem_en and byte offset for stores; data_valid, fun3 and the raw read word for loads.

Parameters:
TIMEOUT, 15, max REQ cycles without dmem_ack before a bus error (>=1)
ADDR_W, 32, address width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  MEM stage holds a load/store
req_store  in  1  1=store, 0=load
req_fun3  in  3  RISC-V fun3 of the access
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (rs2)
stall_o  out  1  freeze IF..MEM
done_o  out  1  one-cycle completion pulse
rdata_o  out  32  captured raw memory word (to wrapper load input)
err_align  out  1  one-cycle pulse: misaligned access or unsupported fun3
err_timeout  out  1  one-cycle pulse: no ack within TIMEOUT
wrap_mem_en  out  1  wrapper store enable
wrap_load  out  1  wrapper data_valid for loads
wrap_byteadd  out  2  latched addr[1:0]
wrap_fun3  out  3  latched fun3
wrap_data  out  32  latched store data (to wrapper data_i)
dmem_req  out  1  memory request
dmem_we  out  1  write enable (store)
dmem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
dmem_ack  in  1  memory done; rdata valid same cycle
dmem_rdata  in  32  memory read word

Behaviour:
- Reset: all outputs 0, state IDLE, latches and counter cleared. Reset is asynchronous: mid-transaction dmem_req and stall_o drop immediately; no completion or error pulse is produced.
- Legal accesses:
  - fun3 000: any offset.
  - fun3 001: offsets 00/01/10.
  - fun3 010: offset 00.
  - Loads only: 100 any offset, 101 offsets 00/01/10, 110 offset 00.
  - Store fun3 >010, 011 and 111 are unsupported and go to err_align.
- IDLE:
  - stall_o = req_valid (combinational).
  - On req_valid: latch store/fun3/addr/wdata.
  - Legal access -> REQ. Otherwise -> ERR, with no dmem_req.
- REQ:
  - dmem_req=1, dmem_we=store, wrap_mem_en=store, stall_o=1.
  - The counter increments each cycle without ack.
  - dmem_ack -> capture dmem_rdata into rdata_o (loads only), go to RESP.
  - Otherwise, once the counter reaches TIMEOUT -> ERR with err_timeout.
  - Ack in the same cycle as expiry: ack wins.
- RESP: done_o=1, wrap_load=load, stall_o=0, then return to IDLE. The pipeline advances at the end of this cycle.
- ERR: err_align or err_timeout =1 for one cycle, stall_o=0, dmem_req=0, then return to IDLE. The trap unit consumes the pulse.
- Timing:
  - Minimum latency is accept to done = 2 cycles after IDLE (IDLE, REQ+ack, RESP).
  - Back-to-back requests have one IDLE cycle between them.
- Hold rules:
  - wrap_byteadd, wrap_fun3, wrap_data and dmem_addr come from the latches and hold from REQ through RESP.
  - rdata_o holds until the next load ack.
- req_* changes while in REQ are ignored.
- A load never asserts dmem_we or wrap_mem_en. A store never asserts wrap_load.
- Counter width: $clog2(TIMEOUT+1); cleared on entry to REQ.

Decomposition:
- Package lsu_pkg:
  - state enum {IDLE, REQ, RESP, ERR}.
  - fun3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU, F3_WU.
  - function access_legal(store, fun3, off).
- Sub-module lsu_align_chk: combinational legality check, reused by the trap unit.

Test Plan:
1. TIMEOUT=15. lw addr 0x100, ack 3rd REQ cycle, rdata 0xDEADBEEF.
   - dmem_req 3 cycles, dmem_addr 0x100, stall high 4 cycles.
   - Then RESP: done=1, wrap_load=1, rdata_o=0xDEADBEEF, wrap_fun3=010, wrap_byteadd=00.
2. sb addr 0x103, wdata 0xAB, immediate ack.
   - REQ: dmem_addr 0x100, dmem_we=1, wrap_mem_en=1, wrap_byteadd=11, wrap_fun3=000.
   - done next cycle, wrap_load=0.
3. lh addr 0x203 (also sw fun3 100) -> err_align one cycle, dmem_req never asserted, done_o=0, stall_o low in the ERR cycle.
4. TIMEOUT=4, lw without ack -> dmem_req exactly 4 cycles, then err_timeout pulse, dmem_req=0, IDLE.
5. rst_n low in the 2nd REQ cycle -> dmem_req and stall_o 0 the same instant, no pulses. After release, the same request is re-accepted and completes normally.
6. sw 0x10 then lw 0x14, immediate acks -> done pulses 3 cycles apart, second dmem_we=0, lw rdata captured correctly.
